hazard_scoreboard: RTL

Parametrised hazard and forwarding unit for the pipelined CPU datapath. It sits beside the decode stage and tracks destination registers of in-flight instructions across NSTAGES post-decode stages (default EX, MEM, WB). For NREAD source operands it produces a forwarding mux select and the forwarded data. It also asserts a decode stall on load-use or unforwardable hazards. It generalises the fixed two-operand forwarding of the single-datapath design to arbitrary operand count, stage depth and load latency, and adds a stall-cycle counter.

---
 rtl/cpu_types_pkg.sv | 28 ++
 rtl/hazard_match.sv | 73 +++++++
 rtl/hazard_scoreboard.sv | 120 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// cpu_types_pkg
// Shared CPU datapath types: hazard scoreboard entry and forwarding constants.
// Build option: HAZARD_FWD_EN selects full forwarding (else stall-only mode).
// Revision: 1.0
// ============================================================================
package cpu_types_pkg;

    // Entry register field is sized for the widest supported register index.
    localparam int c_hz_regw_max = 8;
    localparam int FWD_RF        = 0;

`ifdef HAZARD_FWD_EN
    localparam bit c_hz_fwd_en = 1'b1;
`else
    localparam bit c_hz_fwd_en = 1'b0;
`endif

    typedef struct packed {
        logic                     valid;
        logic                     wen;
        logic [c_hz_regw_max-1:0] wsel;
        logic                     is_load;
    } hz_entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// hazard_match
// Per-operand priority encoder over in-flight entries (youngest stage wins).
// Build option: HAZARD_FWD_EN (via cpu_types_pkg) chooses the stall rule.
// Revision: 1.0
// ============================================================================
module hazard_match
    import cpu_types_pkg::*;
#(
    parameter int NSTAGES = 3,
    parameter int LOADLAT = 1,
    parameter int REGW    = 5,
    parameter int SELW    = 2
) (
    input  logic [NSTAGES*$bits(hz_entry_t)-1:0] i_entries,
    input  logic [REGW-1:0]                      i_rsel,
    input  logic                                 i_used,
    output logic                                 o_hit,
    output logic [SELW-1:0]                      o_stage,
    output logic                                 o_unfwd
);

    localparam int c_ew = $bits(hz_entry_t);

    logic [NSTAGES-1:0]       w_match;
    logic [NSTAGES-1:0]       w_load;
    logic [c_hz_regw_max-1:0] w_rsel;
    logic                     w_win_load;
    logic                     w_early;
    int                       w_win_k;

    assign w_rsel = c_hz_regw_max'(i_rsel);

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        hz_entry_t w_ent;
        assign w_ent      = hz_entry_t'(i_entries[k*c_ew +: c_ew]);
        assign w_load[k]  = w_ent.is_load;
        assign w_match[k] = i_used && (i_rsel != '0) && w_ent.valid &&
                            w_ent.wen && (w_ent.wsel == w_rsel);
    end

    always_comb begin
        o_hit      = 1'b0;
        o_stage    = '0;
        o_unfwd    = 1'b0;
        w_win_load = 1'b0;
        w_win_k    = 0;
        w_early    = 1'b0;
        // Scan oldest to youngest so the youngest match overwrites the rest.
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_hit      = 1'b1;
                o_stage    = SELW'(k);
                w_win_load = w_load[k];
                w_win_k    = k;
            end
        end
        for (int k = 0; k < NSTAGES - 1; k++) begin
            if (w_match[k]) begin
                w_early = 1'b1;
            end
        end
        // Without forwarding only the write-through WB stage is safe to read.
        if (c_hz_fwd_en) begin
            o_unfwd = o_hit && w_win_load && (w_win_k < LOADLAT);
        end else begin
            o_unfwd = w_early;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard
// Decode-side hazard/forwarding unit with stall detection and stall counter.
// Build option: HAZARD_FWD_EN enables operand forwarding from later stages.
// Revision: 1.0
// ============================================================================
module hazard_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int NREAD   = 2,
    parameter int NSTAGES = 3,
    parameter int LOADLAT = 1,
    parameter int REGW    = 5,
    parameter int WORDW   = 32,
    localparam int c_selw = $clog2(NSTAGES + 1)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      advance,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic                      issue_wen,
    input  logic [REGW-1:0]           issue_wsel,
    input  logic                      issue_load,
    input  logic [NREAD*REGW-1:0]     rsel,
    input  logic [NREAD-1:0]          rsel_used,
    input  logic [NREAD*WORDW-1:0]    rdat,
    input  logic [NSTAGES*WORDW-1:0]  stage_wdat,
    output logic                      stall,
    output logic [NREAD*c_selw-1:0]   fwd_sel,
    output logic [NREAD*WORDW-1:0]    fwd_dat,
    output logic [31:0]               stall_cnt
);

    localparam int c_ew = $bits(hz_entry_t);

    hz_entry_t                  r_ent [NSTAGES];
    hz_entry_t                  w_new;
    logic [NSTAGES*c_ew-1:0]    w_ent_flat;
    logic [NREAD-1:0]           w_hit;
    logic [NREAD-1:0]           w_unfwd;
    logic [NREAD*c_selw-1:0]    w_stage;
    logic                       w_stall;
    logic                       w_accept;
    logic [31:0]                r_stall_cnt;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_flat
        assign w_ent_flat[k*c_ew +: c_ew] = r_ent[k];
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        int w_k;

        hazard_match #(
            .NSTAGES (NSTAGES),
            .LOADLAT (LOADLAT),
            .REGW    (REGW),
            .SELW    (c_selw)
        ) u_match (
            .i_entries (w_ent_flat),
            .i_rsel    (rsel[i*REGW +: REGW]),
            .i_used    (rsel_used[i]),
            .o_hit     (w_hit[i]),
            .o_stage   (w_stage[i*c_selw +: c_selw]),
            .o_unfwd   (w_unfwd[i])
        );

        always_comb begin
            w_k = int'(w_stage[i*c_selw +: c_selw]);
            if (c_hz_fwd_en && w_hit[i]) begin
                fwd_sel[i*c_selw +: c_selw] = w_stage[i*c_selw +: c_selw] + c_selw'(1);
                fwd_dat[i*WORDW +: WORDW]   = stage_wdat[w_k*WORDW +: WORDW];
            end else begin
                fwd_sel[i*c_selw +: c_selw] = c_selw'(FWD_RF);
                fwd_dat[i*WORDW +: WORDW]   = rdat[i*WORDW +: WORDW];
            end
        end
    end

    // Flush squashes the decoded instruction, so it can never need a stall.
    assign w_stall  = issue_valid && !flush && (|w_unfwd);
    assign w_accept = issue_valid && !w_stall && !flush;
    assign stall    = w_stall;

    always_comb begin
        w_new = '0;
        if (w_accept) begin
            w_new.valid   = 1'b1;
            w_new.wen     = issue_wen;
            w_new.wsel    = c_hz_regw_max'(issue_wsel);
            w_new.is_load = issue_load;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NSTAGES; k++) begin
                r_ent[k] <= '0;
            end
        end else if (advance) begin
            for (int k = NSTAGES - 1; k > 0; k--) begin
                r_ent[k] <= r_ent[k-1];
            end
            r_ent[0] <= w_new;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
